// File: rtl/rv32i_types.sv
// ----------------------------------------------------------------------------
// rv32i_types
//   Shared types and constants for the instruction-cache memory path.
//   - cladapt_state_t : state encoding of the cache line adapter FSM
//   - CACHELINE_W     : cache line width in bits
//   - BMEM_BEAT_W     : burst memory data width in bits
//   - BMEM_BURST_LEN  : beats per cache line
//   - line_align()    : clears the byte offset of an address within a line
// ----------------------------------------------------------------------------
package rv32i_types;

    localparam int CACHELINE_W    = 256;
    localparam int BMEM_BEAT_W    = 64;
    localparam int BMEM_BURST_LEN = 4;

    // Byte-offset bits inside one cache line (32 bytes -> 5 bits).
    localparam int          LINE_OFFSET_W    = $clog2(CACHELINE_W / 8);
    localparam logic [31:0] LINE_OFFSET_MASK = (32'd1 << LINE_OFFSET_W) - 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        DONE
    } cladapt_state_t;

    // Masking (rather than slicing) keeps every address bit formally used.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~LINE_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// ----------------------------------------------------------------------------
// cacheline_adapter
//   Bridges the instruction cache downstream port (one 256-bit line per
//   request, dfp_*) to a 64-bit burst memory port (bmem_*).
//   - A line read becomes one bmem read request followed by BURST_LEN
//     returning beats, which are assembled into dfp_rdata.
//   - A line writeback becomes a BURST_LEN-beat bmem write burst.
//   - Completion is signalled with a one-cycle dfp_resp pulse.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   dfp_addr      line address from the cache (byte offset ignored)
//   dfp_read      line read request, held until dfp_resp
//   dfp_write     line write request, held until dfp_resp
//   dfp_wdata     line write data
//   dfp_rdata     assembled read line (held until the next read)
//   dfp_resp      one-cycle completion pulse
//   bmem_addr     line-aligned request address
//   bmem_read     read request
//   bmem_write    write beat valid
//   bmem_wdata    write beat data
//   bmem_ready    memory accepts the request / beat this cycle
//   bmem_raddr    address tag of the returning read beat
//   bmem_rdata    returning read beat
//   bmem_rvalid   read beat valid
//
// Build option
//   CLADAPT_RESP_BYPASS_EN : when defined, a read completes in the same cycle
//   as its final tag-matching beat (dfp_resp and the last slot of dfp_rdata
//   come straight from the bmem return path) and the FSM skips DONE.
// ----------------------------------------------------------------------------
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int BEAT_W    = BMEM_BEAT_W,
    parameter int BURST_LEN = BMEM_BURST_LEN
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [31:0]                 dfp_addr,
    input  logic                        dfp_read,
    input  logic                        dfp_write,
    input  logic [BEAT_W*BURST_LEN-1:0] dfp_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] dfp_rdata,
    output logic                        dfp_resp,

    output logic [31:0]                 bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [BEAT_W-1:0]           bmem_wdata,
    input  logic                        bmem_ready,
    input  logic [31:0]                 bmem_raddr,
    input  logic [BEAT_W-1:0]           bmem_rdata,
    input  logic                        bmem_rvalid
);

    localparam int                CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN - 1);

    cladapt_state_t    r_state;
    cladapt_state_t    w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [31:0]       r_addr;
    logic [31:0]       w_addr_next;

    // Read line buffer (feeds dfp_rdata) and write beat buffer. The write
    // data is captured when the request is taken so bmem_wdata is driven
    // from registers only.
    logic [BEAT_W-1:0] r_line [BURST_LEN];
    logic [BEAT_W-1:0] r_wbuf [BURST_LEN];

    logic              w_wbuf_load;
    logic              w_beat_hit;
    logic              w_last_beat;
    logic              w_resp_bypass;

    // A returning beat counts only while waiting and only if its tag
    // matches the line we asked for; anything else is dropped.
    assign w_beat_hit  = (r_state == RD_WAIT) && bmem_rvalid && (bmem_raddr == r_addr);
    assign w_last_beat = (r_cnt == LAST_CNT);

`ifdef CLADAPT_RESP_BYPASS_EN
    assign w_resp_bypass = w_beat_hit && w_last_beat;
`else
    assign w_resp_bypass = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State / counter / address registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Line and write buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BURST_LEN; i++) begin
                r_line[i] <= '0;
                r_wbuf[i] <= '0;
            end
        end else begin
            if (w_beat_hit) begin
                r_line[r_cnt] <= bmem_rdata;
            end
            if (w_wbuf_load) begin
                for (int i = 0; i < BURST_LEN; i++) begin
                    r_wbuf[i] <= dfp_wdata[i*BEAT_W +: BEAT_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_wbuf_load  = 1'b0;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_addr    = '0;
        bmem_wdata   = '0;
        dfp_resp     = w_resp_bypass;

        unique case (r_state)
            IDLE: begin
                // Read has priority if the cache illegally asserts both.
                if (dfp_read) begin
                    w_addr_next  = line_align(dfp_addr);
                    w_state_next = RD_REQ;
                end else if (dfp_write) begin
                    w_addr_next  = line_align(dfp_addr);
                    w_cnt_next   = '0;
                    w_wbuf_load  = 1'b1;
                    w_state_next = WR_BURST;
                end
            end

            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = r_addr;
                if (bmem_ready) begin
                    w_cnt_next   = '0;
                    w_state_next = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (w_beat_hit) begin
                    if (w_last_beat) begin
                        w_cnt_next   = '0;
                        w_state_next = w_resp_bypass ? IDLE : DONE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = r_addr;
                bmem_wdata = r_wbuf[r_cnt];
                if (bmem_ready) begin
                    if (w_last_beat) begin
                        w_cnt_next   = '0;
                        w_state_next = DONE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            DONE: begin
                dfp_resp     = 1'b1;
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read line assembly. With the bypass the final slot is taken from the
    // bmem return path in the completing cycle; the register catches up on
    // the same edge, so later cycles read the identical value.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_rdata
            if (gi == BURST_LEN - 1) begin : g_last
                assign dfp_rdata[gi*BEAT_W +: BEAT_W] = w_resp_bypass ? bmem_rdata : r_line[gi];
            end else begin : g_body
                assign dfp_rdata[gi*BEAT_W +: BEAT_W] = r_line[gi];
            end
        end
    endgenerate

`ifndef SYNTHESIS
    // Simultaneous read and write requests are a cache protocol error.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == IDLE)) begin
            assert (!(dfp_read && dfp_write));
        end
    end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// ----------------------------------------------------------------------------
// tb_cacheline_adapter
//   Randomised scoreboard bench for cacheline_adapter. The driver issues
//   cache line reads/writes and plays the burst memory; for every request it
//   pushes the expected bmem request, write beats and dfp response into
//   queues. A negedge monitor pops and compares whenever the DUT presents
//   an accepted request, an accepted write beat or a dfp_resp.
// ----------------------------------------------------------------------------
module tb_cacheline_adapter;
    import rv32i_types::*;

`ifdef CLADAPT_RESP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            dfp_addr;
    logic                   dfp_read;
    logic                   dfp_write;
    logic [CACHELINE_W-1:0] dfp_wdata;
    logic [CACHELINE_W-1:0] dfp_rdata;
    logic                   dfp_resp;
    logic [31:0]            bmem_addr;
    logic                   bmem_read;
    logic                   bmem_write;
    logic [BMEM_BEAT_W-1:0] bmem_wdata;
    logic                   bmem_ready;
    logic [31:0]            bmem_raddr;
    logic [BMEM_BEAT_W-1:0] bmem_rdata;
    logic                   bmem_rvalid;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues
    logic [31:0]            req_q  [$];   // expected accepted read request address
    logic [95:0]            beat_q [$];   // expected accepted write beat {addr, data}
    logic [CACHELINE_W-1:0] resp_q [$];   // expected dfp_rdata at each dfp_resp

    // Reference model: the line the cache should currently see on dfp_rdata.
    logic [CACHELINE_W-1:0] model_line = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [255:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h with no expectation queued", name, act);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bmem_read && bmem_ready) begin
                if (req_q.size() == 0) unexpected("read_req", 256'(bmem_addr));
                else check("read_req_addr", 256'(bmem_addr), 256'(req_q.pop_front()));
            end
            if (bmem_write && bmem_ready) begin
                if (beat_q.size() == 0) unexpected("write_beat", 256'({bmem_addr, bmem_wdata}));
                else check("write_beat", 256'({bmem_addr, bmem_wdata}), 256'(beat_q.pop_front()));
            end
            if (dfp_resp) begin
                if (resp_q.size() == 0) unexpected("dfp_resp", dfp_rdata);
                else check("dfp_rdata", dfp_rdata, resp_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Each transaction task starts just after a rising
    // edge with the DUT idle and returns in the cycle after dfp_resp with
    // the request dropped, so calls chain back-to-back.
    // ------------------------------------------------------------------
    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall, input int junk_pos,
                           input int gap_max, input bit fixed);
        logic [63:0]  w [4];
        logic [255:0] line;
        logic [31:0]  a;
        int           cyc;
        int           held;
        int           gaps;
        a    = addr & 32'hFFFF_FFE0;
        cyc  = 0;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            w[i] = fixed ? 64'(64'h1111_1111_1111_1111 * 64'(i + 1)) : {$urandom, $urandom};
            line[64*i +: 64] = w[i];
        end
        req_q.push_back(a);
        resp_q.push_back(line);
        model_line = line;
        dfp_addr = addr;
        dfp_read = 1'b1;

        // Request phase: hold ready low for 'stall' cycles of bmem_read.
        do begin
            tick();
            cyc++;
            if (bmem_read) begin
                held++;
                bmem_ready = (held > stall);
            end else begin
                bmem_ready = 1'b0;
            end
        end while (!(bmem_read && bmem_ready) && cyc < 100);
        check("read_req_hold_cycles", 256'(held), 256'(stall + 1));
        tick();
        bmem_ready = 1'b0;
        check("read_req_single", 256'(bmem_read), 256'(0));

        // Return phase: matching beats, optional foreign beat and gaps.
        for (int i = 0; i < 4; i++) begin
            if (i == junk_pos) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'h0000_1000;
                bmem_rdata  = {$urandom, $urandom};
                tick();
            end
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bmem_rvalid = 1'b0;
                tick();
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = w[i];
            if (i < 3) tick();
        end
        #1;
        check("resp_with_last_beat", 256'(dfp_resp), 256'(BYPASS));
        tick();
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        check("resp_after_last_beat", 256'(dfp_resp), 256'(!BYPASS));
        if (dfp_resp) tick();
        dfp_read = 1'b0;
        $display("read  addr=%h stall=%0d junk=%0d line=%h", addr, stall, junk_pos, line);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] data, input bit fixed);
        logic [5:0] pat;
        logic       r;
        int         acc;
        int         k;
        int         cyc;
        pat = 6'b101101;   // consumed LSB first: 1,0,1,1,0,1
        acc = 0;
        k   = 0;
        cyc = 0;
        for (int i = 0; i < 4; i++) beat_q.push_back({addr & 32'hFFFF_FFE0, data[64*i +: 64]});
        resp_q.push_back(model_line);
        dfp_addr  = addr;
        dfp_wdata = data;
        dfp_write = 1'b1;
        while (acc < 4 && cyc < 200) begin
            tick();
            cyc++;
            if (bmem_write) begin
                r = fixed ? ((k < 6) ? pat[k] : 1'b1) : 1'($urandom_range(0, 1));
                k++;
                bmem_ready = r;
                if (r) acc++;
            end else begin
                bmem_ready = 1'b0;
            end
        end
        check("write_beats_accepted", 256'(acc), 256'(4));
        tick();
        bmem_ready = 1'b0;
        check("write_resp", 256'(dfp_resp), 256'(1));
        check("write_done_no_beat", 256'(bmem_write), 256'(0));
        tick();
        dfp_write = 1'b0;
        dfp_wdata = rand_line();
        $display("write addr=%h data=%h", addr, data);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dfp_resp"},   256'(dfp_resp),   256'(0));
        check({tag, "_bmem_read"},  256'(bmem_read),  256'(0));
        check({tag, "_bmem_write"}, 256'(bmem_write), 256'(0));
        check({tag, "_bmem_addr"},  256'(bmem_addr),  256'(0));
        check({tag, "_bmem_wdata"}, 256'(bmem_wdata), 256'(0));
        check({tag, "_dfp_rdata"},  dfp_rdata,        256'(0));
    endtask

    task automatic do_reset_midread(input logic [31:0] addr);
        logic [31:0] a;
        a = addr & 32'hFFFF_FFE0;
        req_q.push_back(a);
        dfp_addr = addr;
        dfp_read = 1'b1;
        tick();                      // RD_REQ
        bmem_ready = 1'b1;
        tick();                      // RD_WAIT
        bmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = {$urandom, $urandom};
            tick();
        end
        bmem_rvalid = 1'b0;
        dfp_read    = 1'b0;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        model_line = '0;
        check_all_zero("after_rst");
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = {$urandom, $urandom};
            tick();
            check("stray_beat_no_resp", 256'(dfp_resp), 256'(0));
        end
        bmem_rvalid = 1'b0;
        check("stray_beats_rdata", dfp_rdata, model_line);
        $display("reset mid-read addr=%h", addr);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst         = 1'b1;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        do_read(32'h1ECE_B000, 0, -1, 0, 1'b1);
        do_read(32'h1ECE_B014, 3, -1, 0, 1'b0);
        do_read(32'h2000_0040, 0, 2, 0, 1'b0);
        do_write(32'h3000_0080, rand_line(), 1'b1);
        do_reset_midread(32'h4000_00C0);
        do_read(32'h4000_00C0, 1, -1, 0, 1'b0);
        // Back-to-back: second request presented the cycle after dfp_resp.
        do_read(32'h5000_0100, 0, -1, 0, 1'b0);
        do_read(32'h5000_0120, 0, -1, 0, 1'b0);
        do_write(32'h6000_0000, rand_line(), 1'b0);
        do_read(32'h6000_0020, 0, -1, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            logic [31:0] ra;
            ra = $urandom | 32'h8000_0000;
            if ($urandom_range(0, 1) == 1)
                do_read(ra, int'($urandom_range(0, 3)),
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1, 2, 1'b0);
            else
                do_write(ra, rand_line(), 1'b0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) tick();
        end

        repeat (4) tick();
        check("req_q_drained",  256'(req_q.size()),  256'(0));
        check("beat_q_drained", 256'(beat_q.size()), 256'(0));
        check("resp_q_drained", 256'(resp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Sits between the instruction cache's downstream port (256-bit line, dfp_*) and the 64-bit burst memory port (bmem_*).
- Converts one cache line read into a single bmem read request followed by a 4-beat return.
- Converts one cache line writeback into a 4-beat bmem write burst.
- Responds to the cache with a one-cycle dfp_resp pulse.

Parameters:
- BEAT_W, 64: bmem data width in bits.
- BURST_LEN, 4: beats per line. LINE_W = BEAT_W*BURST_LEN = 256, derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dfp_addr  in  32  line address from cache; bits [4:0] ignored
- dfp_read  in  1  line read request, held until dfp_resp
- dfp_write  in  1  line write request, held until dfp_resp
- dfp_wdata  in  256  line write data, stable while dfp_write is high
- dfp_rdata  out  256  assembled read line
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  line-aligned address ({addr[31:5],5'b0})
- bmem_read  out  1  read request
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts request/beat this cycle
- bmem_raddr  in  32  address tag of returning read beat
- bmem_rdata  in  64  returning read beat
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset values:
  - state=IDLE, beat counter=0, latched address=0, line buffer=0.
  - All bmem_* outputs=0, dfp_resp=0, dfp_rdata=0.
- Outputs are decoded from registered state, counter and latched address; no combinational path from dfp_* inputs to bmem_*.
- IDLE:
  - dfp_read=1: latch the aligned address, go to RD_REQ.
  - else dfp_write=1: latch the address, go to WR_BURST with cnt=0.
  - Read and write both high is illegal; read wins and a simulation assertion fires.
- RD_REQ:
  - Drive bmem_read=1 and bmem_addr=latched address.
  - bmem_ready=1: go to RD_WAIT with cnt=0. Otherwise hold.
- RD_WAIT:
  - bmem_read=0.
  - On bmem_rvalid=1 with bmem_raddr==latched address: write bmem_rdata into line slot cnt (bits 64*cnt+:64), then cnt++.
  - rvalid beats with a mismatched raddr are dropped.
  - After the beat with cnt==BURST_LEN-1: go to DONE.
- WR_BURST:
  - Drive bmem_write=1, bmem_addr=latched address, bmem_wdata=dfp_wdata[64*cnt+:64].
  - cnt advances only on bmem_ready=1. bmem_ready=0 stalls with the beat held.
  - After the beat with cnt==BURST_LEN-1 is accepted: go to DONE.
- DONE:
  - dfp_resp=1 for exactly one cycle, then IDLE.
  - dfp_rdata holds the assembled line (reads) and keeps it until the next read overwrites a slot. Writes leave it unchanged.
- Minimum latency:
  - Read: request seen in cycle 0 → bmem_read in cycle 1 → dfp_resp 1 cycle after the 4th beat.
  - Write: 4 bmem_write cycles plus 1 cycle of dfp_resp.
- Back-to-back requests: the cache deasserts dfp_read/dfp_write in the cycle after dfp_resp. A request present in IDLE on that cycle is a new transaction; no gap cycle is required.
- rst asserted mid-transaction:
  - Abort immediately to IDLE, clear the counter and all outputs next cycle.
  - Partial write bursts are not completed.
  - Later stray rvalid beats are ignored because state is IDLE.
- Counter is $clog2(BURST_LEN) bits and wraps to 0 on entering DONE.

Optional Feature:
- Macro CLADAPT_RESP_BYPASS_EN.
- Defined:
  - For reads, dfp_resp asserts combinationally in the cycle the final valid, tag-matching beat arrives.
  - dfp_rdata in that cycle is the buffered slots 0..2 plus bmem_rdata in slot 3.
  - FSM goes directly from RD_WAIT to IDLE, saving one cycle.
  - Writes still pass through DONE.
- Undefined: all responses come from DONE as described above.

Decomposition:
- Into rv32i_types:
  - enum cladapt_state_t {IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE}.
  - Constants CACHELINE_W=256, BMEM_BEAT_W=64, BMEM_BURST_LEN=4.
- No sub-module: a single FSM + counter + line buffer module; the line buffer is a simple indexed register array inside it.

Test Plan:
- Read, ready=1, beats 0x11..11 through 0x44..44 at addr 0x1ECEB000 on consecutive cycles after request → one bmem_read cycle with addr 0x1ECEB000. dfp_resp one cycle after the 4th beat. dfp_rdata = {0x44..,0x33..,0x22..,0x11..}.
- Read with dfp_addr=0x1ECEB014, ready low 3 cycles → bmem_read held 4 cycles with addr 0x1ECEB000. Exactly one request accepted.
- Read with an interleaved beat tagged 0x00001000 → beat ignored. Line is built only from the 4 matching beats.
- Write dfp_wdata={D3,D2,D1,D0}, ready toggling 1,0,1,1,0,1 → beats D0,D1,D2,D3 in order. Each beat is held while ready=0. Exactly one dfp_resp afterwards.
- rst asserted after 2 read beats, then 2 stray rvalids → IDLE. No dfp_resp. Outputs all 0. A following read completes normally.
- With CLADAPT_RESP_BYPASS_EN: read test 1 → dfp_resp in the same cycle as beat 4. Back-to-back read accepted the next cycle.
